// File: rtl/subleq_control_unit.sv
// ----------------------------------------------------------------------------
// subleq_control_unit
//
// Microcoded Moore FSM that sequences a SUBLEQ datapath. Each instruction
// fetches three words A, B, C from PC, PC+1 and PC+2, computes
// mem[B] <= mem[B] - mem[A], and branches to C when the result is <= 0
// (otherwise falls through to PC+3). Run/halt/single-step control and a
// completed-instruction counter are provided for the top level.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start               pulse, leaves IDLE/HALT and starts the next instruction
//   halt_req            level, sampled in BR, stops at the instruction boundary
//   step_mode           level, return to IDLE after every instruction
//   flag_z, flag_n      registered ALU flags from the datapath
//   pc_in .. save_flags datapath strobes, decoded from the registered state
//   running, halted     status (execution states / HALT state)
//   instr_count         completed instructions, wraps modulo 2^CNT_W
//   state_dbg           current state code
// ----------------------------------------------------------------------------
module subleq_control_unit #(
    parameter int MAX_INSTR = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             step_mode,
    input  logic             flag_z,
    input  logic             flag_n,
    output logic             pc_in,
    output logic             pc_out,
    output logic             pc_inc,
    output logic             r_in,
    output logic             mar_in,
    output logic             mdr_in,
    output logic             mdr_out,
    output logic             read_mem,
    output logic             write_mem,
    output logic             comp_alu,
    output logic             save_flags,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_A0   = 4'd1,
        S_A1   = 4'd2,
        S_A2   = 4'd3,
        S_A3   = 4'd4,
        S_A4   = 4'd5,
        S_B0   = 4'd6,
        S_B1   = 4'd7,
        S_B2   = 4'd8,
        S_B3   = 4'd9,
        S_EX   = 4'd10,
        S_WR   = 4'd11,
        S_C0   = 4'd12,
        S_C1   = 4'd13,
        S_BR   = 4'd14,
        S_HALT = 4'd15
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_INSTR);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;
    logic             limit_hit;

    // State and counter registers; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // The limit compares for equality only, so after resuming past the limit
    // execution is unlimited until the counter wraps around.
    assign count_inc = count_q + CNT_W'(1);
    assign limit_hit = (MAX_INSTR != 0) && (count_inc == LIMIT);

    // Next-state logic: a straight microcode sequence, with decisions only in
    // the wait states and at the instruction boundary (BR).
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE, S_HALT: if (start) state_d = S_A0;
            S_A0:  state_d = S_A1;
            S_A1:  state_d = S_A2;
            S_A2:  state_d = S_A3;
            S_A3:  state_d = S_A4;
            S_A4:  state_d = S_B0;
            S_B0:  state_d = S_B1;
            S_B1:  state_d = S_B2;
            S_B2:  state_d = S_B3;
            S_B3:  state_d = S_EX;
            S_EX:  state_d = S_WR;
            S_WR:  state_d = S_C0;
            S_C0:  state_d = S_C1;
            S_C1:  state_d = S_BR;
            S_BR: begin
                count_d = count_inc;
                if (limit_hit)      state_d = S_HALT;
                else if (halt_req)  state_d = S_HALT;
                else if (step_mode) state_d = S_IDLE;
                else                state_d = S_A0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe decode from the registered state only. The BR branch decision
    // uses flags captured in EX, which stay stable until the next EX.
    always_comb begin
        pc_in      = 1'b0;
        pc_out     = 1'b0;
        pc_inc     = 1'b0;
        r_in       = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        read_mem   = 1'b0;
        write_mem  = 1'b0;
        comp_alu   = 1'b0;
        save_flags = 1'b0;
        unique case (state_q)
            S_A0, S_B0, S_C0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
            end
            S_A1, S_B1, S_C1: begin
                read_mem = 1'b1;
                pc_inc   = 1'b1;
            end
            S_A2, S_B2: begin
                mdr_out = 1'b1;
                mar_in  = 1'b1;
            end
            S_A3, S_B3: read_mem = 1'b1;
            S_A4: begin
                mdr_out = 1'b1;
                r_in    = 1'b1;
            end
            S_EX: begin
                mdr_out    = 1'b1;
                comp_alu   = 1'b1;
                mdr_in     = 1'b1;
                save_flags = 1'b1;
            end
            S_WR: write_mem = 1'b1;
            S_BR: begin
                if (flag_z | flag_n) begin
                    mdr_out = 1'b1;
                    pc_in   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign running     = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);
    assign instr_count = count_q;
    assign state_dbg   = state_q;

endmodule
